// File: rtl/adder_arb_pkg.sv
// ============================================================================
// adder_arb_pkg : shared types and widths for the adder arbiter slice
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_arb_pkg;

    localparam int DATA_W = 32;
    localparam int SUM_W  = DATA_W + 1;
    localparam int BLK_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : one-hot round-robin grant (fixed priority if
//              ADDER_ARB_FIXED_PRIO_EN is defined)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

`ifdef ADDER_ARB_FIXED_PRIO_EN

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (en && !found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = ID_W'(i);
            end
        end
    end

`else

    logic [ID_W-1:0] ptr;
    logic [ID_W:0]   cand;
    logic            found;

    // Search upward from the pointer, folding back at NUM_REQ (handles non-power-of-2).
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(off);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (en && !found && req[cand[ID_W-1:0]]) begin
                found                    = 1'b1;
                grant[cand[ID_W-1:0]]    = 1'b1;
                idx                      = cand[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (idx == ID_W'(NUM_REQ-1)) ? '0 : idx + ID_W'(1);
        end
    end

`endif

endmodule

`default_nettype wire

// File: rtl/select_adder.sv
// ============================================================================
// select_adder : 32-bit carry-select adder built from 8-bit blocks
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module select_adder
    import adder_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [SUM_W-1:0]  sum
);

    localparam int NUM_BLK = DATA_W / BLK_W;

    logic [NUM_BLK:0] carry;

    assign carry[0] = 1'b0;

    // Each block precomputes both carry-in outcomes; the ripple only drives muxes.
    for (genvar i = 0; i < NUM_BLK; i++) begin : g_blk
        logic [BLK_W:0] s0;
        logic [BLK_W:0] s1;

        assign s0 = {1'b0, a[i*BLK_W +: BLK_W]} + {1'b0, b[i*BLK_W +: BLK_W]};
        assign s1 = {1'b0, a[i*BLK_W +: BLK_W]} + {1'b0, b[i*BLK_W +: BLK_W]} + (BLK_W+1)'(1);

        assign sum[i*BLK_W +: BLK_W] = carry[i] ? s1[BLK_W-1:0] : s0[BLK_W-1:0];
        assign carry[i+1]            = carry[i] ? s1[BLK_W]     : s0[BLK_W];
    end

    assign sum[DATA_W] = carry[NUM_BLK];

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ============================================================================
// adder_arbiter : shares one carry-select adder among NUM_REQ requesters
//                 (ADDER_ARB_FIXED_PRIO_EN selects fixed-priority grant)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [SUM_W-1:0]          rsp_sum
);

    state_t              state;
    state_t              state_nxt;
    logic                arb_en;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                accept;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [ID_W-1:0]     op_id;
    logic [SUM_W-1:0]    sum;

    // Gating with rst keeps req_ready low while reset is held.
    assign arb_en    = (state == IDLE) && !rst;
    assign accept    = |grant;
    assign req_ready = grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .en    (arb_en),
        .grant (grant),
        .idx   (grant_idx)
    );

    select_adder u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
        end else begin
            if (state == IDLE && accept) begin
                op_a  <= req_a[grant_idx*DATA_W +: DATA_W];
                op_b  <= req_b[grant_idx*DATA_W +: DATA_W];
                op_id <= grant_idx;
            end
            if (state == CALC) begin
                rsp_sum   <= sum;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
// tb_adder_arbiter : directed + random bench for adder_arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [32:0]     rsp_sum;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference winner: first set bit scanning from the model pointer.
    function automatic int pick(input logic [N-1:0] v);
`ifdef ADDER_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 0; k < N; k++) if (v[(mptr + k) % N]) return (mptr + k) % N;
`endif
        return -1;
    endfunction

    task automatic txn(input logic [N-1:0] v, input int stall,
                       input bit use_fixed, input logic [31:0] fa, input logic [31:0] fb);
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] exp_sum;
        logic [N-1:0] exp_gnt;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = $urandom;
            req_b[32*i +: 32] = $urandom;
        end
        w = pick(v);
        exp_gnt = '0;
        if (w >= 0) begin
            if (use_fixed) begin
                req_a[32*w +: 32] = fa;
                req_b[32*w +: 32] = fb;
            end
            exp_gnt[w] = 1'b1;
        end
        #1;
        check("grant", 64'(req_ready), 64'(exp_gnt));
        if (w < 0) begin
            req_valid = '0;
            return;
        end
        a = req_a[32*w +: 32];
        b = req_b[32*w +: 32];
        exp_sum = {1'b0, a} + {1'b0, b};
        @(posedge clk);
`ifndef ADDER_ARB_FIXED_PRIO_EN
        mptr = (w + 1) % N;
`endif
        @(negedge clk);
        check("calc_valid", 64'(rsp_valid), 64'd0);
        check("calc_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_sum", 64'(rsp_sum), 64'(exp_sum));
        check("rsp_id", 64'(rsp_id), 64'(w));
        check("resp_ready", 64'(req_ready), 64'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_sum", 64'(rsp_sum), 64'(exp_sum));
            check("hold_id", 64'(rsp_id), 64'(w));
            check("hold_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_done", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_sum", 64'(rsp_sum), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        rst       = 1'b0;

        // Single request and carry out
        txn(4'b0001, 0, 1'b1, 32'h0000_0005, 32'h0000_0003);
        txn(4'b0100, 0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);

        // Reset during CALC discards the operation
        @(negedge clk);
        req_valid = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_sum", 64'(rsp_sum), 64'd0);
        check("mid_rst_id", 64'(rsp_id), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("mid_rst_hold", 64'(rsp_valid), 64'd0);
        rst       = 1'b0;
        req_valid = '0;
        mptr      = 0;

        // Fairness from a fresh pointer: 0,1,2,3,0
        for (int i = 0; i < 5; i++) txn(4'b1111, 0, 1'b0, 32'd0, 32'd0);

        // Requester 1 after reset, then wrap with gaps and backpressure
        txn(4'b0010, 0, 1'b0, 32'd0, 32'd0);
        txn(4'b0100, 0, 1'b0, 32'd0, 32'd0);
        txn(4'b0101, 5, 1'b0, 32'd0, 32'd0);
        txn(4'b0101, 0, 1'b0, 32'd0, 32'd0);
        txn(4'b0000, 0, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 24; i++) begin
            txn(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0, 32'd0, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
